sad_fetch_sequencer: RTL and testbench

SAD_FETCH_SEQUENCER -- requirements
Module: sad_fetch_sequencer

---
 rtl/sad_fetch_sequencer_pkg.sv | 22 ++
 rtl/sad_fetch_sequencer_if.sv | 12 +
 rtl/sad_req_counter.sv | 33 +++
 rtl/sad_fetch_sequencer.sv | 170 +++++++++++++++++
 tb/tb_sad_fetch_sequencer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sad_fetch_sequencer_pkg.sv
// Shared types and constants for the SAD fetch sequencer.
package sad_fetch_sequencer_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WIN_WORDS  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WIN_REQ,
    S_FRM_REQ,
    S_DRAIN,
    S_DONE
  } state_t;

  // Drops the byte-lane bits of a byte address.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sad_fetch_sequencer_if.sv
// Memory read request / response bus between the sequencer and memory.
interface sad_fetch_sequencer_if;
  import sad_fetch_sequencer_pkg::*;

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rsp_valid;

  modport master (output req_valid, req_addr, input req_ready, rsp_valid);
  modport slave  (input req_valid, req_addr, output req_ready, rsp_valid);
endinterface

// File: rtl/sad_req_counter.sv
// Outstanding read request counter with look-ahead full flag.
module sad_req_counter #(
  parameter  int unsigned MAX_OUT = 4,
  localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic [CNT_W-1:0] o_count_nxt_c,
  output logic             o_full_nxt_c
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  always_comb begin
    w_count_nxt = r_count;
    if (i_inc && !i_dec)      w_count_nxt = r_count + CNT_W'(1);
    else if (!i_inc && i_dec) w_count_nxt = r_count - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= '0;
    else        r_count <= w_count_nxt;
  end

  assign o_count       = r_count;
  assign o_count_nxt_c = w_count_nxt;
  assign o_full_nxt_c  = (w_count_nxt == CNT_W'(MAX_OUT));

endmodule

// File: rtl/sad_fetch_sequencer.sv
// Fetches a 4-word window then a frame row, steering each returned word into
// the SAD shift registers and strobing the min register with candidate tags.
module sad_fetch_sequencer
  import sad_fetch_sequencer_pkg::*;
#(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  sad_fetch_sequencer_if.master        bus,
  input  logic                         i_start,
  input  logic [ADDR_W-1:0]            i_win_base,
  input  logic [ADDR_W-1:0]            i_frm_base,
  input  logic [LEN_W-1:0]             i_frm_len,
  output logic                         o_window_shift_c,
  output logic                         o_frame_shift_c,
  output logic                         o_min_in_c,
  output logic [ADDR_W-1:0]            o_tag_c,
  output logic                         o_min_clear,
  output logic                         o_load_min,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);
  localparam int unsigned RW    = LEN_W + 1;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_win_base, r_frm_base;
  logic [LEN_W-1:0]  r_len;
  logic [RW-1:0]     r_iss, w_iss_nxt;
  logic [RW-1:0]     r_rsp, w_rsp_nxt;
  logic              r_req_valid, w_req_valid_nxt;
  logic [ADDR_W-1:0] r_req_addr, w_req_addr_nxt;
  logic              r_err, w_err_nxt;
  logic              r_min_clear, r_load_min, r_busy, r_done;
  logic              w_cap;

  logic              w_hs, w_rsp_ok, w_stray, w_fetching, w_full_nxt;
  logic [CNT_W-1:0]  w_count, w_count_nxt;
  logic [RW-1:0]     w_j;

  assign w_hs       = r_req_valid && bus.req_ready;
  assign w_fetching = (r_state == S_WIN_REQ) || (r_state == S_FRM_REQ) || (r_state == S_DRAIN);
  assign w_rsp_ok   = bus.rsp_valid && w_fetching && (w_count != '0);
  assign w_stray    = bus.rsp_valid && !w_rsp_ok;

  sad_req_counter #(.MAX_OUT(MAX_OUT)) u_req_counter (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_inc         (w_hs),
    .i_dec         (w_rsp_ok),
    .o_count       (w_count),
    .o_count_nxt_c (w_count_nxt),
    .o_full_nxt_c  (w_full_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_iss_nxt       = r_iss;
    w_rsp_nxt       = w_rsp_ok ? r_rsp + RW'(1) : r_rsp;
    w_req_addr_nxt  = r_req_addr;
    w_req_valid_nxt = 1'b0;
    w_err_nxt       = r_err || w_stray;
    w_cap           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_cap     = 1'b1;
          w_iss_nxt = '0;
          w_rsp_nxt = '0;
          if (i_frm_len < LEN_W'(WIN_WORDS)) begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_CLEAR;
            w_err_nxt   = w_stray;
          end
        end
      end
      S_CLEAR: begin
        w_state_nxt    = S_WIN_REQ;
        w_req_addr_nxt = r_win_base;
      end
      S_WIN_REQ: begin
        if (w_hs) begin
          if (r_iss == RW'(WIN_WORDS - 1)) begin
            w_state_nxt    = S_FRM_REQ;
            w_iss_nxt      = '0;
            w_req_addr_nxt = r_frm_base;
          end else begin
            w_iss_nxt      = r_iss + RW'(1);
            w_req_addr_nxt = r_req_addr + ADDR_W'(WORD_BYTES);
          end
        end
      end
      S_FRM_REQ: begin
        if (w_hs) begin
          w_iss_nxt      = r_iss + RW'(1);
          w_req_addr_nxt = r_req_addr + ADDR_W'(WORD_BYTES);
          if (r_iss + RW'(1) == {1'b0, r_len}) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((w_count_nxt == '0) && (w_rsp_nxt == {1'b0, r_len} + RW'(WIN_WORDS)))
          w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // A pending request is held until accepted; a fresh one needs a free slot.
    if ((w_state_nxt == S_WIN_REQ) || (w_state_nxt == S_FRM_REQ))
      w_req_valid_nxt = (r_req_valid && !w_hs) || !w_full_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_base  <= '0;
      r_frm_base  <= '0;
      r_len       <= '0;
      r_iss       <= '0;
      r_rsp       <= '0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_err       <= 1'b0;
      r_min_clear <= 1'b0;
      r_load_min  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_cap) begin
        r_win_base <= word_align(i_win_base);
        r_frm_base <= word_align(i_frm_base);
        r_len      <= i_frm_len;
      end
      r_iss       <= w_iss_nxt;
      r_rsp       <= w_rsp_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_err       <= w_err_nxt;
      r_min_clear <= (w_state_nxt == S_CLEAR);
      r_load_min  <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  // Frame word j >= 3 completes the candidate starting at frame word j-3.
  assign w_j              = r_rsp - RW'(WIN_WORDS + 3);
  assign o_window_shift_c = w_rsp_ok && (r_rsp < RW'(WIN_WORDS));
  assign o_frame_shift_c  = w_rsp_ok && (r_rsp >= RW'(WIN_WORDS));
  assign o_min_in_c       = w_rsp_ok && (r_rsp >= RW'(WIN_WORDS + 3));
  assign o_tag_c          = o_min_in_c ? r_frm_base + (ADDR_W'(w_j) * ADDR_W'(WORD_BYTES)) : '0;

  assign bus.req_valid = r_req_valid;
  assign bus.req_addr  = r_req_addr;
  assign o_min_clear   = r_min_clear;
  assign o_load_min    = r_load_min;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule

// File: tb/tb_sad_fetch_sequencer.sv
// Scoreboard bench for sad_fetch_sequencer with a latency-configurable memory model.
module tb_sad_fetch_sequencer;
  import sad_fetch_sequencer_pkg::*;

  localparam int unsigned LEN_W   = 16;
  localparam int unsigned MAX_OUT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [31:0]       i_win_base = '0;
  logic [31:0]       i_frm_base = '0;
  logic [LEN_W-1:0]  i_frm_len = '0;
  logic              o_window_shift_c, o_frame_shift_c, o_min_in_c;
  logic [31:0]       o_tag_c;
  logic              o_min_clear, o_load_min, o_busy, o_done, o_err;

  sad_fetch_sequencer_if bus();

  sad_fetch_sequencer #(.LEN_W(LEN_W), .MAX_OUT(MAX_OUT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .i_start          (i_start),
    .i_win_base       (i_win_base),
    .i_frm_base       (i_frm_base),
    .i_frm_len        (i_frm_len),
    .o_window_shift_c (o_window_shift_c),
    .o_frame_shift_c  (o_frame_shift_c),
    .o_min_in_c       (o_min_in_c),
    .o_tag_c          (o_tag_c),
    .o_min_clear      (o_min_clear),
    .o_load_min       (o_load_min),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_err            (o_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rsp_delay = 1;
  bit          mem_en = 1'b0;
  bit          stray = 1'b0;
  bit          ready_toggle = 1'b0;
  int          due_q[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_tag[$];
  int          exp_shift[$];
  int          hs_cnt, ws_cnt, fs_cnt, min_cnt, rsp_seen, last_rsp_cyc;
  int          tb_out, max_out_seen, full_cycles;
  bit          prev_pend, prev_full, prev_hs;
  logic [31:0] prev_addr;

  // Memory: answers each accepted request rsp_delay cycles later, in order.
  task automatic drive_mem();
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mem_en && due_q.size() > 0 && due_q[0] <= cyc) begin
        bus.rsp_valid = 1'b1;
        void'(due_q.pop_front());
      end else begin
        bus.rsp_valid = stray;
      end
      bus.req_ready = ready_toggle ? !bus.req_ready : 1'b1;
    end
  endtask

  // Scoreboard: pops expected address/shift/tag entries as the DUT produces them.
  task automatic monitor();
    logic [31:0] e;
    int          k;
    bit          hs;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_pend = 1'b0;
        prev_full = 1'b0;
        prev_hs   = 1'b0;
      end else begin
        hs = bus.req_valid && bus.req_ready;
        if (prev_pend) begin
          n_checks++;
          if (bus.req_valid !== 1'b1 || bus.req_addr !== prev_addr) begin
            n_fail++;
            $display("FAIL req_hold valid=%b addr=%h required addr=%h", bus.req_valid, bus.req_addr, prev_addr);
          end
        end
        if (prev_full) begin
          n_checks++;
          if (hs || (!prev_hs && bus.req_addr !== prev_addr)) begin
            n_fail++;
            $display("FAIL full_stall hs=%b addr=%h required no handshake, addr=%h", hs, bus.req_addr, prev_addr);
          end
        end
        if (bus.rsp_valid && mem_en) begin
          tb_out--;
          rsp_seen++;
          last_rsp_cyc = cyc;
          n_checks++;
          if (o_window_shift_c + o_frame_shift_c != 1) begin
            n_fail++;
            $display("FAIL one_shift win=%b frm=%b required exactly one", o_window_shift_c, o_frame_shift_c);
          end else begin
            k = o_window_shift_c ? 1 : 2;
            if (o_window_shift_c) ws_cnt++; else fs_cnt++;
            if (exp_shift.size() == 0) begin
              n_fail++;
              $display("FAIL shift_kind got=%0d required none", k);
            end else if (k != exp_shift.pop_front()) begin
              n_fail++;
              $display("FAIL shift_kind got=%0d required other kind", k);
            end
          end
          if (o_min_in_c) begin
            min_cnt++;
            n_checks++;
            if (exp_tag.size() == 0) begin
              n_fail++;
              $display("FAIL tag got=%h required no min_in", o_tag_c);
            end else begin
              e = exp_tag.pop_front();
              if (o_tag_c !== e) begin
                n_fail++;
                $display("FAIL tag got=%h required=%h", o_tag_c, e);
              end
            end
          end
        end else if (o_window_shift_c || o_frame_shift_c || o_min_in_c) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_shift win=%b frm=%b min=%b required 0", o_window_shift_c, o_frame_shift_c, o_min_in_c);
        end
        if (hs) begin
          hs_cnt++;
          tb_out++;
          due_q.push_back(cyc + rsp_delay);
          n_checks++;
          if (exp_addr.size() == 0) begin
            n_fail++;
            $display("FAIL req_addr got=%h required no request", bus.req_addr);
          end else begin
            e = exp_addr.pop_front();
            if (bus.req_addr !== e) begin
              n_fail++;
              $display("FAIL req_addr got=%h required=%h", bus.req_addr, e);
            end
          end
          n_checks++;
          if (tb_out > MAX_OUT) begin
            n_fail++;
            $display("FAIL outstanding got=%0d required <= %0d", tb_out, MAX_OUT);
          end
          if (tb_out > max_out_seen) max_out_seen = tb_out;
        end
        if (o_done || o_load_min) begin
          n_checks++;
          if (o_done !== o_load_min) begin
            n_fail++;
            $display("FAIL load_min got=%b required=%b", o_load_min, o_done);
          end
        end
        if (tb_out == MAX_OUT) full_cycles++;
        prev_full = (tb_out == MAX_OUT);
        prev_pend = bus.req_valid && !bus.req_ready;
        prev_hs   = hs;
        prev_addr = bus.req_addr;
      end
    end
  endtask

  task automatic clear_stats();
    hs_cnt = 0; ws_cnt = 0; fs_cnt = 0; min_cnt = 0; rsp_seen = 0;
    last_rsp_cyc = -10; max_out_seen = 0; full_cycles = 0;
  endtask

  task automatic expect_search(input logic [31:0] win, input logic [31:0] frm, input int len);
    logic [31:0] wa, fa;
    wa = {win[31:2], 2'b00};
    fa = {frm[31:2], 2'b00};
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(wa + 32'(4 * i));
      exp_shift.push_back(1);
    end
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(fa + 32'(4 * i));
      exp_shift.push_back(2);
    end
    for (int j = 3; j < len; j++) exp_tag.push_back(fa + 32'(4 * (j - 3)));
  endtask

  task automatic pulse_start(input logic [31:0] win, input logic [31:0] frm, input int len);
    @(posedge clk); #1;
    i_win_base = win; i_frm_base = frm; i_frm_len = LEN_W'(len); i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output int dc, output bit lm);
    seen = 1'b0; dc = 0; lm = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (o_done) begin seen = 1'b1; dc = cyc; lm = o_load_min; end
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({o_busy, o_done, o_err, o_min_clear, o_load_min, bus.req_valid, o_window_shift_c,
         o_frame_shift_c, o_min_in_c} !== 9'b0 || bus.req_addr !== 32'h0 || o_tag_c !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b done=%b err=%b rv=%b addr=%h tag=%h required all 0",
               o_busy, o_done, o_err, bus.req_valid, bus.req_addr, o_tag_c);
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    mem_en = 1'b1;
  endtask

  task automatic test_basic();
    bit seen, lm; int dc;
    clear_stats(); rsp_delay = 1; ready_toggle = 1'b0;
    expect_search(32'h0000_1000, 32'h0000_2000, 8);
    pulse_start(32'h0000_1000, 32'h0000_2000, 8);
    @(negedge clk);
    n_checks++;
    if (o_min_clear !== 1'b1 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_state min_clear=%b busy=%b required 1 1", o_min_clear, o_busy);
    end
    @(negedge clk);
    n_checks++;
    if (o_min_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_len min_clear=%b required 0", o_min_clear);
    end
    wait_done(seen, dc, lm);
    n_checks++;
    if (!seen || dc != last_rsp_cyc + 1 || !lm) begin
      n_fail++;
      $display("FAIL basic_done seen=%b cycle=%0d load_min=%b required 1 %0d 1", seen, dc, lm, last_rsp_cyc + 1);
    end
    @(negedge clk);
    n_checks++;
    if (hs_cnt != 12 || ws_cnt != 4 || fs_cnt != 8 || min_cnt != 5 || o_err !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_counts req=%0d ws=%0d fs=%0d min=%0d err=%b busy=%b required 12 4 8 5 0 0",
               hs_cnt, ws_cnt, fs_cnt, min_cnt, o_err, o_busy);
    end
    n_checks++;
    if (exp_addr.size() + exp_shift.size() + exp_tag.size() != 0) begin
      n_fail++;
      $display("FAIL basic_leftover got=%0d required 0", exp_addr.size() + exp_shift.size() + exp_tag.size());
    end
  endtask

  task automatic test_backpressure();
    bit seen, lm; int dc;
    clear_stats(); rsp_delay = 5; ready_toggle = 1'b0;
    expect_search(32'h0000_4003, 32'h0000_5001, 6);
    pulse_start(32'h0000_4003, 32'h0000_5001, 6);
    wait_done(seen, dc, lm);
    @(negedge clk);
    n_checks++;
    if (!seen || max_out_seen != MAX_OUT || full_cycles == 0 || hs_cnt != 10 || min_cnt != 3) begin
      n_fail++;
      $display("FAIL backpressure done=%b max_out=%0d full=%0d req=%0d min=%0d required 1 %0d >0 10 3",
               seen, max_out_seen, full_cycles, hs_cnt, min_cnt, MAX_OUT);
    end
    n_checks++;
    if (exp_addr.size() + exp_shift.size() + exp_tag.size() != 0) begin
      n_fail++;
      $display("FAIL bp_leftover got=%0d required 0", exp_addr.size() + exp_shift.size() + exp_tag.size());
    end
    rsp_delay = 1;
  endtask

  task automatic test_ready_toggle();
    bit seen, lm; int dc;
    clear_stats(); rsp_delay = 1; ready_toggle = 1'b1;
    expect_search(32'h0000_0100, 32'h0000_0200, 7);
    pulse_start(32'h0000_0100, 32'h0000_0200, 7);
    wait_done(seen, dc, lm);
    @(negedge clk);
    n_checks++;
    if (!seen || hs_cnt != 11 || fs_cnt != 7 || min_cnt != 4 || exp_addr.size() != 0) begin
      n_fail++;
      $display("FAIL ready_toggle done=%b req=%0d fs=%0d min=%0d left=%0d required 1 11 7 4 0",
               seen, hs_cnt, fs_cnt, min_cnt, exp_addr.size());
    end
    ready_toggle = 1'b0;
  endtask

  task automatic test_short_len();
    bit seen, lm; int dc;
    clear_stats();
    pulse_start(32'h0000_0300, 32'h0000_0400, 3);
    wait_done(seen, dc, lm);
    n_checks++;
    if (!seen || o_err !== 1'b1) begin
      n_fail++;
      $display("FAIL short_done done=%b err=%b required 1 1", seen, o_err);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (hs_cnt != 0 || o_err !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL short_idle req=%0d err=%b busy=%b required 0 1 0", hs_cnt, o_err, o_busy);
    end
    expect_search(32'h0000_0300, 32'h0000_0400, 4);
    pulse_start(32'h0000_0300, 32'h0000_0400, 4);
    @(negedge clk);
    n_checks++;
    if (o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear err=%b required 0", o_err);
    end
    wait_done(seen, dc, lm);
    @(negedge clk);
    n_checks++;
    if (!seen || min_cnt != 1 || hs_cnt != 8 || exp_tag.size() != 0) begin
      n_fail++;
      $display("FAIL len4 done=%b min=%0d req=%0d required 1 1 8", seen, min_cnt, hs_cnt);
    end
  endtask

  task automatic test_start_during();
    bit seen, lm; int dc;
    clear_stats();
    expect_search(32'h0000_0600, 32'hFFFF_FFF6, 8);
    pulse_start(32'h0000_0600, 32'hFFFF_FFF6, 8);
    for (int i = 0; i < 200 && hs_cnt < 6; i++) @(negedge clk);
    pulse_start(32'h0000_0A00, 32'h0000_0B00, 5);
    wait_done(seen, dc, lm);
    repeat (3) @(negedge clk);
    n_checks++;
    if (!seen || hs_cnt != 12 || min_cnt != 5 || o_busy !== 1'b0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored done=%b req=%0d min=%0d busy=%b err=%b required 1 12 5 0 0",
               seen, hs_cnt, min_cnt, o_busy, o_err);
    end
    n_checks++;
    if (exp_addr.size() + exp_shift.size() + exp_tag.size() != 0) begin
      n_fail++;
      $display("FAIL start_leftover got=%0d required 0", exp_addr.size() + exp_shift.size() + exp_tag.size());
    end
  endtask

  task automatic test_reset_abort();
    clear_stats();
    expect_search(32'h0000_0700, 32'h0000_0800, 10);
    pulse_start(32'h0000_0700, 32'h0000_0800, 10);
    for (int i = 0; i < 200 && rsp_seen < 6; i++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    mem_en = 1'b0;
    due_q.delete(); exp_addr.delete(); exp_shift.delete(); exp_tag.delete();
    tb_out = 0;
    #1;
    n_checks++;
    if ({o_busy, o_done, o_err, o_min_clear, o_load_min, bus.req_valid, o_window_shift_c,
         o_frame_shift_c, o_min_in_c} !== 9'b0 || bus.req_addr !== 32'h0 || o_tag_c !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_reset busy=%b rv=%b addr=%h ws=%b fs=%b required all 0",
               o_busy, bus.req_valid, bus.req_addr, o_window_shift_c, o_frame_shift_c);
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || o_window_shift_c !== 1'b0 || o_frame_shift_c !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_shift rsp=%b ws=%b fs=%b required 1 0 0", bus.rsp_valid, o_window_shift_c, o_frame_shift_c);
    end
    stray = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_err !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_err err=%b busy=%b required 1 0", o_err, o_busy);
    end
    mem_en = 1'b1;
  endtask

  initial begin
    bus.req_ready = 1'b1;
    bus.rsp_valid = 1'b0;
    clear_stats();
    tb_out = 0;
    prev_addr = '0;
    fork
      drive_mem();
      monitor();
    join_none
    test_reset();
    test_basic();
    test_backpressure();
    test_ready_toggle();
    test_short_len();
    test_start_during();
    test_reset_abort();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
